// File: rtl/xge_arb_pkg.sv
// Shared types and sizing for the MAC transmit packet arbiter.
package xge_arb_pkg;

  localparam int MAX_REQ = 8;
  localparam int GRANT_W = 3;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/tx_pkt_arbiter_if.sv
// Requester-side and MAC-side packet handshake bundle for tx_pkt_arbiter.
interface tx_pkt_arbiter_if #(
  parameter int NUM_REQ = 4
);

  logic [NUM_REQ-1:0]    req_val;
  logic [NUM_REQ-1:0]    req_sop;
  logic [NUM_REQ-1:0]    req_eop;
  logic [3*NUM_REQ-1:0]  req_mod;
  logic [64*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]    req_rdy;

  logic                  pkt_tx_full;
  logic                  pkt_tx_val;
  logic                  pkt_tx_sop;
  logic                  pkt_tx_eop;
  logic [2:0]            pkt_tx_mod;
  logic [63:0]           pkt_tx_data;

  // master: the packet sources plus the MAC; slave: the arbiter
  modport master (
    output req_val, req_sop, req_eop, req_mod, req_data, pkt_tx_full,
    input  req_rdy, pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, pkt_tx_data
  );

  modport slave (
    input  req_val, req_sop, req_eop, req_mod, req_data, pkt_tx_full,
    output req_rdy, pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, pkt_tx_data
  );

endinterface

// File: rtl/tx_pkt_arbiter_rr_pick.sv
// Round-robin first-one finder: lowest request index at or after ptr, wrapping.
module rr_pick
  import xge_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GRANT_W-1:0] ptr,
  output logic               found,
  output logic [GRANT_W-1:0] idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    // k is the distance from ptr; the first hit in distance order wins
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req[i] && (((int'(ptr) + k) % NUM_REQ) == i)) begin
          found = 1'b1;
          idx   = GRANT_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/tx_pkt_arbiter.sv
// Packet-granular round-robin arbiter sharing the MAC pkt_tx port among NUM_REQ sources.
//   state     | meaning
//   ARB_IDLE  | no owner; arbitrate SOP requests, discard orphan beats
//   ARB_GRANT | grant_id owns pkt_tx from SOP until its accepted EOP
module tx_pkt_arbiter
  import xge_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk_156m25,
  input  logic               reset_156m25_n,
  tx_pkt_arbiter_if.slave    bus,
  output logic [GRANT_W-1:0] grant_id,
  output logic               busy,
  output logic [31:0]        pkt_cnt,
  output logic [CNT_W-1:0]   drop_cnt
);

  arb_state_t         state;
  logic [GRANT_W-1:0] rr_ptr;
  logic [NUM_REQ-1:0] cand;
  logic [NUM_REQ-1:0] orphan;
  logic               pick_found;
  logic [GRANT_W-1:0] pick_idx;

  logic               own_val;
  logic               own_sop;
  logic               own_eop;
  logic [2:0]         own_mod;
  logic [63:0]        own_data;
  logic               accept;

  assign cand   = bus.req_val & bus.req_sop;
  assign orphan = bus.req_val & ~bus.req_sop;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .req   (cand),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    own_val  = 1'b0;
    own_sop  = 1'b0;
    own_eop  = 1'b0;
    own_mod  = '0;
    own_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == GRANT_W'(i)) begin
        own_val  = bus.req_val[i];
        own_sop  = bus.req_sop[i];
        own_eop  = bus.req_eop[i];
        own_mod  = bus.req_mod[3*i +: 3];
        own_data = bus.req_data[64*i +: 64];
      end
    end
  end

  // Owner ready depends only on state, grant_id and full so no loop through req_val
  always_comb begin
    bus.req_rdy = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (state == ARB_GRANT)
        bus.req_rdy[i] = (grant_id == GRANT_W'(i)) && !bus.pkt_tx_full;
      else
        bus.req_rdy[i] = orphan[i];
    end
  end

  assign accept = (state == ARB_GRANT) && own_val && !bus.pkt_tx_full;

  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      state           <= ARB_IDLE;
      rr_ptr          <= '0;
      grant_id        <= '0;
      busy            <= 1'b0;
      pkt_cnt         <= '0;
      drop_cnt        <= '0;
      bus.pkt_tx_val  <= 1'b0;
      bus.pkt_tx_sop  <= 1'b0;
      bus.pkt_tx_eop  <= 1'b0;
      bus.pkt_tx_mod  <= '0;
      bus.pkt_tx_data <= '0;
    end else begin
      bus.pkt_tx_val  <= accept;
      bus.pkt_tx_sop  <= accept && own_sop;
      bus.pkt_tx_eop  <= accept && own_eop;
      bus.pkt_tx_mod  <= (accept && own_eop) ? own_mod : 3'd0;
      bus.pkt_tx_data <= accept ? own_data : 64'd0;

      case (state)
        ARB_IDLE: begin
          if (|orphan && (drop_cnt != '1))
            drop_cnt <= drop_cnt + CNT_W'(1);
          if (pick_found) begin
            grant_id <= pick_idx;
            state    <= ARB_GRANT;
            busy     <= 1'b1;
          end
        end
        ARB_GRANT: begin
          if (accept && own_eop) begin
            pkt_cnt <= pkt_cnt + 32'd1;
            rr_ptr  <= (grant_id == GRANT_W'(NUM_REQ - 1)) ? '0 : grant_id + GRANT_W'(1);
            state   <= ARB_IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          state <= ARB_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
